// File: rtl/conv2d_kernel_scheduler_if.sv
// conv2d_kernel_scheduler_if: config, pixel-in, conv2d-out and schedule signals of the kernel scheduler
interface conv2d_kernel_scheduler_if #(
    parameter int WidthIn     = 1,
    parameter int KernelWidth = 3,
    parameter int WeightWidth = 2,
    parameter int NumKernels  = 4
);
    localparam int KernelArea = KernelWidth * KernelWidth;
    localparam int BankW      = NumKernels > 1 ? $clog2(NumKernels) : 1;
    localparam int TapW       = KernelArea > 1 ? $clog2(KernelArea) : 1;
    logic                              cfg_valid_i;
    logic                              cfg_ready_o;
    logic [BankW-1:0]                  cfg_bank_i;
    logic [TapW-1:0]                   cfg_tap_i;
    logic [WeightWidth-1:0]            cfg_weight_i;
    logic [NumKernels-1:0]             bank_en_i;
    logic                              pix_valid_i;
    logic                              pix_ready_o;
    logic [WidthIn-1:0]                pix_data_i;
    logic                              conv_valid_o;
    logic                              conv_ready_i;
    logic [WidthIn-1:0]                conv_data_o;
    logic [KernelArea*WeightWidth-1:0] weights_o;
    logic [BankW-1:0]                  kernel_id_o;
    logic                              frame_start_o;
    modport master (
        output cfg_valid_i, cfg_bank_i, cfg_tap_i, cfg_weight_i, bank_en_i,
               pix_valid_i, pix_data_i, conv_ready_i,
        input  cfg_ready_o, pix_ready_o, conv_valid_o, conv_data_o,
               weights_o, kernel_id_o, frame_start_o
    );
    modport slave (
        input  cfg_valid_i, cfg_bank_i, cfg_tap_i, cfg_weight_i, bank_en_i,
               pix_valid_i, pix_data_i, conv_ready_i,
        output cfg_ready_o, pix_ready_o, conv_valid_o, conv_data_o,
               weights_o, kernel_id_o, frame_start_o
    );
endinterface

// File: rtl/conv2d_kernel_scheduler.sv
// conv2d_kernel_scheduler: round-robin weight-bank selection per frame with frame-gated pixel pass-through
module conv2d_kernel_scheduler #(
    parameter int LineWidthPx = 160,
    parameter int LineCountPx = 120,
    parameter int WidthIn     = 1,
    parameter int KernelWidth = 3,
    parameter int WeightWidth = 2,
    parameter int NumKernels  = 4
) (
    input logic clk_i,
    input logic rst_i,
    conv2d_kernel_scheduler_if.slave io
);
    localparam int KernelArea = KernelWidth * KernelWidth;
    localparam int BankW      = NumKernels > 1 ? $clog2(NumKernels) : 1;
    localparam int TapW       = KernelArea > 1 ? $clog2(KernelArea) : 1;
    localparam int FrameLen   = LineWidthPx * LineCountPx;
    localparam int CntW       = FrameLen > 1 ? $clog2(FrameLen) : 1;
    localparam int WeightsW   = KernelArea * WeightWidth;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BankW-1:0]    active_q, active_d, last_q, last_d;
    logic                fs_q, fs_d;
    logic [WeightsW-1:0] bank_q [NumKernels];
    logic [WeightsW-1:0] bank_d [NumKernels];
    logic                fire, cfg_fire, found;
    logic [BankW-1:0]    sel;

    // Descending scan so the bank closest after `last` overwrites farther ones.
    function automatic logic [BankW:0] pick(input logic [NumKernels-1:0] en, input logic [BankW-1:0] last);
        int idx;
        pick = '0;
        for (int i = NumKernels; i >= 1; i--) begin
            idx = (int'(last) + i) % NumKernels;
            if (en[BankW'(idx)]) pick = {1'b1, BankW'(idx)};
        end
    endfunction

    assign {found, sel}     = pick(io.bank_en_i, last_q);
    assign io.cfg_ready_o   = !(state_q == STREAM && io.cfg_bank_i == active_q);
    assign cfg_fire         = io.cfg_valid_i && io.cfg_ready_o;
    assign io.conv_valid_o  = state_q == STREAM && io.pix_valid_i;
    assign io.pix_ready_o   = state_q == STREAM && io.conv_ready_i;
    assign io.conv_data_o   = WidthIn'(io.pix_data_i);
    assign fire             = io.conv_valid_o && io.conv_ready_i;
    assign io.weights_o     = bank_q[active_q];
    assign io.kernel_id_o   = active_q;
    assign io.frame_start_o = fs_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        last_d   = last_q;
        fs_d     = 1'b0;
        bank_d   = bank_q;
        if (state_q == IDLE && found) begin
            state_d  = STREAM;
            active_d = sel;
            last_d   = sel;
            fs_d     = 1'b1;
        end
        if (fire) begin
            cnt_d   = cnt_q == CntW'(FrameLen - 1) ? '0 : cnt_q + 1'b1;
            state_d = cnt_q == CntW'(FrameLen - 1) ? IDLE : state_q;
        end
        // Out-of-range taps and banks are acknowledged but dropped.
        if (cfg_fire && {1'b0, io.cfg_tap_i} < (TapW + 1)'(KernelArea)
                     && {1'b0, io.cfg_bank_i} < (BankW + 1)'(NumKernels))
            bank_d[io.cfg_bank_i][int'(io.cfg_tap_i) * WeightWidth +: WeightWidth] = io.cfg_weight_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            active_q <= '0;
            last_q   <= BankW'(NumKernels - 1);
            fs_q     <= 1'b0;
            bank_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            last_q   <= last_d;
            fs_q     <= fs_d;
            bank_q   <= bank_d;
        end
    end
endmodule

// File: tb/tb_conv2d_kernel_scheduler.sv
// tb_conv2d_kernel_scheduler: table-driven and randomized checks against a bank/round-robin reference model
module tb_conv2d_kernel_scheduler;
    localparam int W = 4, H = 3, NK = 4, KW = 3, WW = 2, KA = 9, FL = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv2d_kernel_scheduler_if #(.WidthIn(1), .KernelWidth(KW), .WeightWidth(WW), .NumKernels(NK)) bus();
    conv2d_kernel_scheduler #(.LineWidthPx(W), .LineCountPx(H), .WidthIn(1), .KernelWidth(KW),
                              .WeightWidth(WW), .NumKernels(NK)) dut (.clk_i(clk), .rst_i(rst), .io(bus));

    int checks = 0;
    int errors = 0;
    logic [1:0] mw [NK][KA];
    int last_m;

    typedef struct {
        logic [3:0] en;
        int         kid;
    } frame_vec_t;
    frame_vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] pack(input int b);
        logic [17:0] p = '0;
        for (int t = 0; t < KA; t++) p[t*WW +: WW] = mw[b][t];
        return p;
    endfunction

    function automatic int pick_m(input logic [3:0] en, input int last);
        int k;
        for (int i = 1; i <= NK; i++) begin
            k = (last + i) % NK;
            if (en[k[1:0]]) return k;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.cfg_valid_i = 0; bus.cfg_bank_i = 0; bus.cfg_tap_i = 0; bus.cfg_weight_i = 0;
        bus.bank_en_i = 0; bus.pix_valid_i = 0; bus.pix_data_i = 0; bus.conv_ready_i = 0;
    endtask

    task automatic reset_dut;
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
        for (int b = 0; b < NK; b++) for (int t = 0; t < KA; t++) mw[b][t] = 2'b00;
        last_m = NK - 1;
    endtask

    task automatic cfg_write(input int b, input int t, input logic [1:0] w);
        bus.cfg_valid_i = 1; bus.cfg_bank_i = 2'(b); bus.cfg_tap_i = 4'(t); bus.cfg_weight_i = w;
        #4;
        chk("cfg_ready_idle", bus.cfg_ready_o, 1);
        tick();
        bus.cfg_valid_i = 0;
        if (t < KA && b < NK) mw[b][t] = w;
    endtask

    task automatic load_random;
        for (int b = 0; b < NK; b++) for (int t = 0; t < KA; t++) cfg_write(b, t, 2'($urandom));
    endtask

    // Called in an IDLE cycle; streams one full frame and returns in the following bubble cycle.
    task automatic run_frame(input logic [3:0] en, input int exp_id, input bit stall);
        int fires = 0;
        int cyc = 0;
        logic v, r, d;
        logic [17:0] w_exp;
        w_exp = pack(exp_id);
        bus.bank_en_i = en; bus.pix_valid_i = 1; bus.conv_ready_i = 1;
        #4;
        chk("idle_pix_ready", bus.pix_ready_o, 0);
        chk("idle_conv_valid", bus.conv_valid_o, 0);
        tick();
        while (fires < FL && cyc < 200) begin
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            d = 1'($urandom);
            bus.pix_valid_i = v; bus.conv_ready_i = r; bus.pix_data_i = d;
            #4;
            chk("frame_start", bus.frame_start_o, cyc == 0);
            chk("kernel_id", bus.kernel_id_o, 64'(exp_id));
            chk("weights", bus.weights_o, w_exp);
            chk("conv_valid", bus.conv_valid_o, v);
            chk("pix_ready", bus.pix_ready_o, r);
            if (v && r) begin
                chk("conv_data", bus.conv_data_o, d);
                fires++;
            end
            tick();
            cyc++;
        end
        chk("frame_fires", fires, FL);
        last_m = exp_id;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running, required to finish");
        $fatal(1);
    end

    initial begin
        logic [17:0] w_frame;
        logic [1:0] nv;
        logic [3:0] en;
        int id;
        tbl = '{'{4'b1011, 0}, '{4'b1011, 1}, '{4'b1011, 3}, '{4'b1011, 0}, '{4'b0100, 2},
                '{4'b0110, 1}, '{4'b0110, 2}, '{4'b1000, 3}, '{4'b0001, 0}, '{4'b1111, 1}};

        // Idle after reset: nothing passes, outputs at reset values.
        reset_dut();
        bus.pix_valid_i = 1; bus.conv_ready_i = 1;
        for (int c = 0; c < 20; c++) begin
            #4;
            chk("rst_pix_ready", bus.pix_ready_o, 0);
            chk("rst_conv_valid", bus.conv_valid_o, 0);
            chk("rst_weights", bus.weights_o, 0);
            chk("rst_kernel_id", bus.kernel_id_o, 0);
            tick();
        end

        // Single enabled bank with known weights, plus a discarded out-of-range tap.
        bus.pix_valid_i = 0;
        for (int t = 0; t < KA; t++) cfg_write(2, t, t % 3 == 0 ? 2'b01 : t % 3 == 1 ? 2'b11 : 2'b00);
        cfg_write(2, 12, 2'b11);
        run_frame(4'b0100, 2, 0);
        bus.bank_en_i = 0;
        #4;
        chk("bubble_pix_ready", bus.pix_ready_o, 0);
        chk("bubble_conv_valid", bus.conv_valid_o, 0);
        tick();

        // Round-robin schedule table, back-to-back frames.
        reset_dut();
        load_random();
        foreach (tbl[i]) run_frame(tbl[i].en, tbl[i].kid, 0);

        // Config writes during a frame on bank 1.
        reset_dut();
        load_random();
        w_frame = pack(1);
        bus.bank_en_i = 4'b0010; bus.pix_valid_i = 1; bus.conv_ready_i = 1;
        tick();
        for (int c = 0; c < FL; c++) begin
            if (c == 6) bus.bank_en_i = 4'b0000;
            if (c >= 5) begin
                bus.cfg_valid_i = 1;
                bus.cfg_bank_i = c == 8 ? 2'd3 : 2'd1;
                bus.cfg_tap_i = c == 8 ? 4'd4 : 4'd0;
                bus.cfg_weight_i = c == 8 ? ~mw[3][4] : mw[1][0] + 2'd1;
            end
            #4;
            chk("mid_kernel_id", bus.kernel_id_o, 1);
            chk("mid_weights", bus.weights_o, w_frame);
            if (c >= 5) chk("mid_cfg_ready", bus.cfg_ready_o, c == 8);
            tick();
            if (c == 8) mw[3][4] = ~mw[3][4];
        end
        nv = mw[1][0] + 2'd1;
        bus.cfg_bank_i = 2'd1; bus.cfg_tap_i = 4'd0; bus.cfg_weight_i = nv;
        #4;
        chk("post_cfg_ready", bus.cfg_ready_o, 1);
        chk("post_pix_ready", bus.pix_ready_o, 0);
        tick();
        bus.cfg_valid_i = 0;
        mw[1][0] = nv;
        last_m = 1;
        run_frame(4'b0010, 1, 0);
        run_frame(4'b1000, 3, 0);

        // Random stalls and random enable masks scheduled by the model.
        for (int f = 0; f < 3; f++) begin
            en = 4'($urandom_range(1, 15));
            id = pick_m(en, last_m);
            run_frame(en, id, 1);
        end

        // Reset in the middle of a frame.
        reset_dut();
        load_random();
        cfg_write(0, 0, 2'b01);
        cfg_write(2, 0, 2'b01);
        bus.bank_en_i = 4'b0100; bus.pix_valid_i = 1; bus.conv_ready_i = 1;
        tick();
        for (int c = 0; c < 7; c++) tick();
        rst = 1;
        tick();
        rst = 0;
        bus.bank_en_i = 0;
        #4;
        chk("mrst_pix_ready", bus.pix_ready_o, 0);
        chk("mrst_conv_valid", bus.conv_valid_o, 0);
        chk("mrst_weights", bus.weights_o, 0);
        chk("mrst_kernel_id", bus.kernel_id_o, 0);
        chk("mrst_frame_start", bus.frame_start_o, 0);
        tick();
        for (int b = 0; b < NK; b++) for (int t = 0; t < KA; t++) mw[b][t] = 2'b00;
        last_m = NK - 1;
        run_frame(4'b1111, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
